// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Accepts MULT/MULTU/DIV/DIVU on a start handshake and iterates one bit per clock
// on operand magnitudes. A final FIX cycle applies the sign correction. The
// 2*WIDTH result is then presented on hi_o/lo_o together with a one-cycle done_o.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       ctrl_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_zero_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Two's-complement negation of a single-width value.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negation of a double-width value.
   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [2*WIDTH-1:0]  acc_q;      // MULT: {partial hi, multiplier}; DIV: {remainder, quotient}
   logic [WIDTH-1:0]    opnd_q;     // MULT: multiplicand magnitude; DIV: divisor magnitude
   logic                is_div_q;
   logic                neg_hi_q;
   logic                neg_lo_q;
   logic                dz_pend_q;
   logic                busy_q;
   logic                done_q;
   logic                div_zero_q;
   logic [WIDTH-1:0]    hi_q;
   logic [WIDTH-1:0]    lo_q;

   // Decode and operand-magnitude signals, used only at acceptance.
   logic                op_ok_s;
   logic                is_div_s;
   logic                is_sgn_s;
   logic                src2_zero_s;
   logic                sign1_s;
   logic                sign2_s;
   logic [WIDTH-1:0]    mag1_s;
   logic [WIDTH-1:0]    mag2_s;
   logic                neg_hi_s;
   logic                neg_lo_s;

   // Iteration and sign-correction results.
   logic [WIDTH:0]      mul_sum_d;
   logic [WIDTH:0]      div_trial_d;
   logic [WIDTH+1:0]    div_sub_d;
   logic [2*WIDTH-1:0]  acc_calc_d;
   logic [2*WIDTH-1:0]  prod_neg_d;
   logic [WIDTH-1:0]    hi_fix_d;
   logic [WIDTH-1:0]    lo_fix_d;

   // Decode the op code, form operand magnitudes and the sign-correction flags.
   always_comb begin
      op_ok_s = 1'b0;
      case (ctrl_i)
         4'b1000, 4'b1001, 4'b1010, 4'b1011: op_ok_s = start_i;
         default:                            op_ok_s = 1'b0;
      endcase
      is_div_s    = ctrl_i[1];
      is_sgn_s    = ~ctrl_i[0];
      src2_zero_s = (src2_i == {WIDTH{1'b0}});
      sign1_s     = is_sgn_s & src1_i[WIDTH-1];
      sign2_s     = is_sgn_s & src2_i[WIDTH-1];
      // A zero divisor leaves the dividend untouched so hi_o returns src1 as-is.
      if (sign1_s && !(is_div_s && src2_zero_s)) begin
         mag1_s = neg_w(src1_i);
      end else begin
         mag1_s = src1_i;
      end
      if (sign2_s) begin
         mag2_s = neg_w(src2_i);
      end else begin
         mag2_s = src2_i;
      end
      if (!is_div_s) begin
         neg_hi_s = sign1_s ^ sign2_s;
         neg_lo_s = sign1_s ^ sign2_s;
      end else if (src2_zero_s) begin
         neg_hi_s = 1'b0;
         neg_lo_s = 1'b0;
      end else begin
         neg_hi_s = sign1_s;
         neg_lo_s = sign1_s ^ sign2_s;
      end
   end

   // One shift-add or restoring shift-subtract step, plus the FIX-stage result.
   always_comb begin
      // Multiply: add the multiplicand into the upper half with a carry bit, then shift right.
      if (acc_q[0]) begin
         mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      end else begin
         mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      end
      // Divide: shift the next dividend bit into the remainder and trial-subtract.
      div_trial_d = acc_q[2*WIDTH-1:WIDTH-1];
      div_sub_d   = {1'b0, div_trial_d} - {2'b00, opnd_q};
      if (is_div_q) begin
         if (div_sub_d[WIDTH+1]) begin
            acc_calc_d = {div_trial_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end else begin
            acc_calc_d = {div_sub_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_calc_d = {mul_sum_d, acc_q[WIDTH-1:1]};
      end
      prod_neg_d = neg_2w(acc_q);
      if (!is_div_q) begin
         if (neg_lo_q) begin
            {hi_fix_d, lo_fix_d} = prod_neg_d;
         end else begin
            {hi_fix_d, lo_fix_d} = acc_q;
         end
      end else begin
         if (neg_hi_q) begin
            hi_fix_d = neg_w(acc_q[2*WIDTH-1:WIDTH]);
         end else begin
            hi_fix_d = acc_q[2*WIDTH-1:WIDTH];
         end
         if (neg_lo_q) begin
            lo_fix_d = neg_w(acc_q[WIDTH-1:0]);
         end else begin
            lo_fix_d = acc_q[WIDTH-1:0];
         end
      end
   end

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         acc_q      <= {(2*WIDTH){1'b0}};
         opnd_q     <= {WIDTH{1'b0}};
         is_div_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         dz_pend_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (op_ok_s) begin
                  state_q    <= ST_CALC;
                  busy_q     <= 1'b1;
                  cnt_q      <= {CNT_W{1'b0}};
                  is_div_q   <= is_div_s;
                  neg_hi_q   <= neg_hi_s;
                  neg_lo_q   <= neg_lo_s;
                  dz_pend_q  <= is_div_s & src2_zero_s;
                  div_zero_q <= 1'b0;
                  if (is_div_s) begin
                     opnd_q <= mag2_s;
                     acc_q  <= {{WIDTH{1'b0}}, mag1_s};
                  end else begin
                     opnd_q <= mag1_s;
                     acc_q  <= {{WIDTH{1'b0}}, mag2_s};
                  end
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ST_CALC: begin
               acc_q <= acc_calc_d;
               cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == CNT_LAST) begin
                  state_q <= ST_FIX;
               end else begin
                  state_q <= ST_CALC;
               end
            end
            ST_FIX: begin
               hi_q       <= hi_fix_d;
               lo_q       <= lo_fix_d;
               div_zero_q <= dz_pend_q;
               done_q     <= 1'b1;
               state_q    <= ST_DONE;
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign div_zero_o = div_zero_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative 32-bit multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It handles the operations the combinational ALU cannot complete in one cycle. It accepts an operation on a start handshake, iterates one bit per clock, and returns a 64-bit result as hi/lo registers with a one-cycle done pulse. Operation codes use the same 4-bit control bus as the ALU and occupy codes the ALU does not decode.

Parameters:
WIDTH, 32, operand width; hi_o/lo_o are WIDTH each; iteration count = WIDTH.

Ports:
clk_i  input  1  clock; all state changes on rising edge.
rst_i  input  1  asynchronous, active-low reset.
src1_i  input  WIDTH  multiplicand / dividend.
src2_i  input  WIDTH  multiplier / divisor.
ctrl_i  input  4  operation: 4'b1000 MULT (signed), 4'b1001 MULTU, 4'b1010 DIV (signed), 4'b1011 DIVU.
start_i  input  1  request; sampled only in IDLE.
busy_o  output  1  high from the edge that accepts start_i until the edge that leaves DONE.
done_o  output  1  one-cycle pulse; hi_o/lo_o valid from the same cycle.
hi_o  output  WIDTH  MULT*: product[63:32]; DIV*: remainder.
lo_o  output  WIDTH  MULT*: product[31:0]; DIV*: quotient.
div_zero_o  output  1  set with done_o when a DIV*/DIVU divisor was 0; held until the next accepted start.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; busy_o, done_o, div_zero_o = 0; hi_o, lo_o = 0; counter and datapath registers = 0. Reset mid-operation aborts the operation with no done_o.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if start_i=1 and ctrl_i is one of the four codes, do all of the following on the edge: latch operands and op, load the datapath, set counter=0, go to CALC, set busy_o=1.
- IDLE, unsupported code: start_i with any other ctrl_i is ignored; the unit stays IDLE.
- CALC: one shift-add (MULT*) or restoring shift-subtract (DIV*) step per clock, operating on operand magnitudes. After the 32nd step (counter==WIDTH-1), go to FIX.
- FIX: apply the sign correction, then go to DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient sign = sign1 XOR sign2; remainder sign = sign of the dividend.
  - Unsigned ops: no correction.
- DONE: hi_o/lo_o (and div_zero_o) update on the edge entering DONE; done_o=1 for exactly this cycle. Next edge goes to IDLE, busy_o=0.
- Latency: done_o is high in the cycle after the 34th rising edge following the edge that sampled start_i (1 accept + 32 CALC + 1 FIX edges). Back-to-back throughput is one op per 35 cycles.
- start_i while not IDLE (including DONE): ignored; the in-flight operation is unaffected.
- Operands and ctrl_i may change after acceptance without effect.
- hi_o/lo_o hold the last result until the next DONE; they are never cleared at start.
- Divide by zero (src2 latched = 0):
  - DIVU: lo_o=32'hFFFFFFFF, hi_o=src1.
  - DIV: lo_o=32'hFFFFFFFF, hi_o=src1 (unsigned iteration result, FIX sign correction skipped).
  - Both: div_zero_o=1, latency unchanged.
- Signed overflow: DIV 32'h80000000 / 32'hFFFFFFFF gives lo_o=32'h80000000, hi_o=0, no flag.
- Magnitude of 32'h80000000 is taken as the unsigned value 2^31; the datapath carries a 33rd bit where required.

Test Plan:
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi_o=32'hFFFFFFFE, lo_o=32'h00000001; done_o one cycle, exactly 34 edges after the start edge; busy_o low the following cycle.
- MULT -3 x 7 -> hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFEB.
- MULT 32'h80000000 x 32'h80000000 -> hi_o=32'h40000000, lo_o=0.
- DIVU 100 / 7 -> lo_o=14, hi_o=2.
- DIV -7 / 2 -> lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF.
- DIV 32'h80000000 / -1 -> lo_o=32'h80000000, hi_o=0, div_zero_o=0.
- DIVU 5 / 0 -> lo_o=32'hFFFFFFFF, hi_o=5, div_zero_o=1. A following MULTU 2 x 3 clears div_zero_o at acceptance and gives lo_o=6.
- Start MULTU 3 x 4, pulse start_i with DIVU at cycles 5 and 34, change src1_i mid-op -> a single done_o with lo_o=12; no second done_o. Then ctrl_i=4'b0010 with start_i -> busy_o stays 0.
- Assert rst_i=0 at CALC cycle 10 -> all outputs 0 asynchronously, no done_o. After release, DIVU 9 / 3 -> lo_o=3, hi_o=0 with normal latency.
